// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD perturbation sequencer: FSM state
// encoding and the saturating arithmetic helpers used on the data words.
// The helpers work on a wide container; callers sign-extend FP_WIDTH-bit
// operands into it and pass FP_WIDTH as the effective width.
package spgd_pkg;

  // Width of the helper container; FP_WIDTH must stay below this.
  localparam int SPGD_MAX_W = 128;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LATCH      = 3'd1,
    S_SETTLE_POS = 3'd2,
    S_MEAS_POS   = 3'd3,
    S_SETTLE_NEG = 3'd4,
    S_MEAS_NEG   = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // Two's-complement negate of a w-bit value; the most-negative w-bit value
  // has no positive counterpart and maps to the most-positive one instead.
  function automatic logic signed [SPGD_MAX_W-1:0] sat_neg(
    input logic signed [SPGD_MAX_W-1:0] x,
    input int                           w
  );
    logic signed [SPGD_MAX_W-1:0] hi;
    logic signed [SPGD_MAX_W-1:0] lo;
    hi = (SPGD_MAX_W'(1) << (w - 1)) - SPGD_MAX_W'(1);
    lo = ~hi;
    if (x == lo) return hi;
    return -x;
  endfunction

  // a - b for w-bit operands, evaluated one bit wider than the container so
  // it never wraps, then clamped to the signed w-bit range.
  function automatic logic signed [SPGD_MAX_W-1:0] sat_sub(
    input logic signed [SPGD_MAX_W-1:0] a,
    input logic signed [SPGD_MAX_W-1:0] b,
    input int                           w
  );
    logic signed [SPGD_MAX_W-1:0] hi;
    logic signed [SPGD_MAX_W:0]   hi_x;
    logic signed [SPGD_MAX_W:0]   lo_x;
    logic signed [SPGD_MAX_W:0]   d;
    hi   = (SPGD_MAX_W'(1) << (w - 1)) - SPGD_MAX_W'(1);
    hi_x = {1'b0, hi};
    lo_x = ~hi_x;
    d    = {a[SPGD_MAX_W-1], a} - {b[SPGD_MAX_W-1], b};
    if (d > hi_x) return hi_x[SPGD_MAX_W-1:0];
    if (d < lo_x) return lo_x[SPGD_MAX_W-1:0];
    return d[SPGD_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/spgd_cycle_timer.sv
// Loadable down-counter with a zero flag. Holds at zero once reached.
module spgd_cycle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spgd_pert_seq.sv
// SPGD perturbation sequencer: latches a PRNG perturbation pair, applies
// +pert and then -pert to the DAC with a settle period after each update,
// captures the cost metric in each phase and reports the saturated
// difference J(+) - J(-).
// Optional feature macro: SPGD_PERT_TIMEOUT_EN (metric-wait timeout + err).
module spgd_pert_seq
  import spgd_pkg::*;
#(
  parameter int FP_WIDTH       = 64,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [FP_WIDTH-1:0] sigma_in,
  output logic [FP_WIDTH-1:0] prng_sigma,
  input  logic [FP_WIDTH-1:0] pert_a_in,
  input  logic [FP_WIDTH-1:0] pert_b_in,
  input  logic [FP_WIDTH-1:0] metric_in,
  input  logic                metric_valid,
  output logic [FP_WIDTH-1:0] dac_a,
  output logic [FP_WIDTH-1:0] dac_b,
  output logic                dac_valid,
  output logic [FP_WIDTH-1:0] pert_a,
  output logic [FP_WIDTH-1:0] pert_b,
  output logic [FP_WIDTH-1:0] delta,
  output logic                done,
  output logic                busy,
  output logic                err
);

`ifdef SPGD_PERT_TIMEOUT_EN
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (TO_W > 8) ? TO_W : 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  localparam int CNT_W = 8;
`endif
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  function automatic logic signed [SPGD_MAX_W-1:0] sext(
    input logic signed [FP_WIDTH-1:0] x
  );
    return {{(SPGD_MAX_W-FP_WIDTH){x[FP_WIDTH-1]}}, x};
  endfunction

  state_t                     state;
  logic signed [FP_WIDTH-1:0] j_pos;
  logic                       tmr_load;
  logic                       tmr_dec;
  logic [CNT_W-1:0]           tmr_val;
  logic                       tmr_zero;

  logic signed [SPGD_MAX_W-1:0] neg_a_full;
  logic signed [SPGD_MAX_W-1:0] neg_b_full;
  logic signed [SPGD_MAX_W-1:0] delta_full;
  logic signed [FP_WIDTH-1:0]   neg_a;
  logic signed [FP_WIDTH-1:0]   neg_b;
  logic signed [FP_WIDTH-1:0]   delta_sat;
  logic                         unused_hi;

`ifdef SPGD_PERT_TIMEOUT_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // Saturating negation of the latched pair and J(+) - J(-) against the live metric.
  always_comb begin
    neg_a_full = sat_neg(sext(pert_a), FP_WIDTH);
    neg_b_full = sat_neg(sext(pert_b), FP_WIDTH);
    delta_full = sat_sub(sext(j_pos), sext(metric_in), FP_WIDTH);
    neg_a      = neg_a_full[FP_WIDTH-1:0];
    neg_b      = neg_b_full[FP_WIDTH-1:0];
    delta_sat  = delta_full[FP_WIDTH-1:0];
  end

  // Upper container bits are sign copies after clamping and carry no information.
  assign unused_hi = ^{neg_a_full[SPGD_MAX_W-1:FP_WIDTH],
                       neg_b_full[SPGD_MAX_W-1:FP_WIDTH],
                       delta_full[SPGD_MAX_W-1:FP_WIDTH]};

  // Timer control: settle count loaded on entry to each settle state, and
  // (with the timeout feature) the metric-wait count loaded on entry to MEAS.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = SETTLE_LOAD;
    case (state)
      S_LATCH: tmr_load = 1'b1;
      S_SETTLE_POS, S_SETTLE_NEG: begin
        if (tmr_zero) begin
`ifdef SPGD_PERT_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
`endif
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_MEAS_POS: begin
        if (metric_valid) begin
          tmr_load = 1'b1;
        end else begin
`ifdef SPGD_PERT_TIMEOUT_EN
          tmr_dec = 1'b1;
`endif
        end
      end
      S_MEAS_NEG: begin
`ifdef SPGD_PERT_TIMEOUT_EN
        tmr_dec = ~metric_valid;
`endif
      end
      default: ;
    endcase
  end

  spgd_cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .dec     (tmr_dec),
    .zero    (tmr_zero)
  );

  // Sequencer FSM and all registered outputs. dac_valid and done default low
  // so every set below is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      prng_sigma <= '0;
      pert_a     <= '0;
      pert_b     <= '0;
      dac_a      <= '0;
      dac_b      <= '0;
      dac_valid  <= 1'b0;
      delta      <= '0;
      done       <= 1'b0;
      j_pos      <= '0;
`ifdef SPGD_PERT_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        dac_a     <= '0;
        dac_b     <= '0;
        dac_valid <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state      <= S_LATCH;
              prng_sigma <= sigma_in;
`ifdef SPGD_PERT_TIMEOUT_EN
              err_q      <= 1'b0;
`endif
            end
          end
          S_LATCH: begin
            state     <= S_SETTLE_POS;
            pert_a    <= pert_a_in;
            pert_b    <= pert_b_in;
            dac_a     <= pert_a_in;
            dac_b     <= pert_b_in;
            dac_valid <= 1'b1;
          end
          S_SETTLE_POS: if (tmr_zero) state <= S_MEAS_POS;
          S_MEAS_POS: begin
            if (metric_valid) begin
              state     <= S_SETTLE_NEG;
              j_pos     <= metric_in;
              dac_a     <= neg_a;
              dac_b     <= neg_b;
              dac_valid <= 1'b1;
            end
`ifdef SPGD_PERT_TIMEOUT_EN
            else if (tmr_zero) begin
              state     <= S_IDLE;
              err_q     <= 1'b1;
              dac_a     <= '0;
              dac_b     <= '0;
              dac_valid <= 1'b1;
            end
`endif
          end
          S_SETTLE_NEG: if (tmr_zero) state <= S_MEAS_NEG;
          S_MEAS_NEG: begin
            if (metric_valid) begin
              state <= S_DONE;
              delta <= delta_sat;
              done  <= 1'b1;
            end
`ifdef SPGD_PERT_TIMEOUT_EN
            else if (tmr_zero) begin
              state     <= S_IDLE;
              err_q     <= 1'b1;
              dac_a     <= '0;
              dac_b     <= '0;
              dac_valid <= 1'b1;
            end
`endif
          end
          S_DONE: begin
            state     <= S_IDLE;
            dac_a     <= '0;
            dac_b     <= '0;
            dac_valid <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spgd_pert_seq.sv
// Directed self-checking bench for spgd_pert_seq (SETTLE_CYCLES=4,
// TIMEOUT_CYCLES=16). The timeout section is built only when
// SPGD_PERT_TIMEOUT_EN is defined.
module tb_spgd_pert_seq;

  localparam int W = 64;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst, start, abort, metric_valid;
  logic [W-1:0] sigma_in, pert_a_in, pert_b_in, metric_in;
  logic [W-1:0] prng_sigma, dac_a, dac_b, pert_a, pert_b, delta;
  logic         dac_valid, done, busy, err;

  int total = 0;
  int bad   = 0;

  spgd_pert_seq #(
    .FP_WIDTH      (W),
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .sigma_in    (sigma_in),
    .prng_sigma  (prng_sigma),
    .pert_a_in   (pert_a_in),
    .pert_b_in   (pert_b_in),
    .metric_in   (metric_in),
    .metric_valid(metric_valid),
    .dac_a       (dac_a),
    .dac_b       (dac_b),
    .dac_valid   (dac_valid),
    .pert_a      (pert_a),
    .pert_b      (pert_b),
    .delta       (delta),
    .done        (done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk64(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // One full iteration with metric_valid held high; edge numbers count from
  // the edge that samples start (E0). done is expected after E(2S+3).
  task automatic do_iter(input string tag, input logic [W-1:0] sig,
                         input logic [W-1:0] pa, input logic [W-1:0] pb,
                         input logic [W-1:0] jp, input logic [W-1:0] jm,
                         input logic [W-1:0] na, input logic [W-1:0] nb,
                         input logic [W-1:0] exp_delta);
    sigma_in     = sig;
    pert_a_in    = pa;
    pert_b_in    = pb;
    metric_in    = jp;
    metric_valid = 1'b1;
    start        = 1'b1;
    tick();                                   // E0 -> LATCH
    chk1 ({tag, "_busy_latch"}, busy, 1'b1);
    chk64({tag, "_sigma"}, prng_sigma, sig);
    chk1 ({tag, "_err_clr"}, err, 1'b0);
    start = 1'b0;
    tick();                                   // E1 -> SETTLE_POS
    chk64({tag, "_dac_a_pos"}, dac_a, pa);
    chk64({tag, "_dac_b_pos"}, dac_b, pb);
    chk1 ({tag, "_dv_pos"}, dac_valid, 1'b1);
    chk64({tag, "_pert_a"}, pert_a, pa);
    chk64({tag, "_pert_b"}, pert_b, pb);
    pert_a_in = ~pa;
    pert_b_in = ~pb;
    tick();                                   // E2
    chk1 ({tag, "_dv_pulse"}, dac_valid, 1'b0);
    tick_n(S - 1);                            // E(S+1) -> MEAS_POS
    chk64({tag, "_dac_a_hold"}, dac_a, pa);
    tick();                                   // E(S+2) -> SETTLE_NEG
    chk64({tag, "_dac_a_neg"}, dac_a, na);
    chk64({tag, "_dac_b_neg"}, dac_b, nb);
    chk1 ({tag, "_dv_neg"}, dac_valid, 1'b1);
    metric_in = jm;
    tick_n(S);                                // E(2S+2) -> MEAS_NEG
    chk1 ({tag, "_done_early"}, done, 1'b0);
    tick();                                   // E(2S+3) -> DONE
    chk1 ({tag, "_done"}, done, 1'b1);
    chk64({tag, "_delta"}, delta, exp_delta);
    chk64({tag, "_pert_a_kept"}, pert_a, pa);
    start = 1'b1;                             // ignored in DONE
    tick();                                   // E(2S+4) -> IDLE
    start = 1'b0;
    chk1 ({tag, "_done_pulse"}, done, 1'b0);
    chk1 ({tag, "_busy_end"}, busy, 1'b0);
    chk64({tag, "_dac_a_zero"}, dac_a, '0);
    chk64({tag, "_dac_b_zero"}, dac_b, '0);
    chk1 ({tag, "_dv_zero"}, dac_valid, 1'b1);
    chk64({tag, "_delta_kept"}, delta, exp_delta);
    tick();
    chk1 ({tag, "_no_restart"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; metric_valid = 1'b0;
    sigma_in = '0; pert_a_in = '0; pert_b_in = '0; metric_in = '0;
    tick_n(2);
    chk1 ("rst_busy", busy, 1'b0);
    chk1 ("rst_done", done, 1'b0);
    chk1 ("rst_dv", dac_valid, 1'b0);
    chk1 ("rst_err", err, 1'b0);
    chk64("rst_dac_a", dac_a, '0);
    chk64("rst_delta", delta, '0);
    chk64("rst_sigma", prng_sigma, '0);
    rst = 1'b0;
    tick();

    // Basic iteration: +0x10/-5, J(+)=100, J(-)=40.
    do_iter("basic", 64'h1234, 64'h10, 64'hFFFF_FFFF_FFFF_FFFB,
            64'd100, 64'd40,
            64'hFFFF_FFFF_FFFF_FFF0, 64'h5, 64'd60);

    // Most-negative perturbation and positive delta saturation.
    do_iter("satpos", 64'h77, 64'h8000_0000_0000_0000, 64'h1,
            64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h7FFF_FFFF_FFFF_FFFF);

    // Negative delta saturation; zero perturbation negates to zero.
    do_iter("satneg", 64'h5, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,
            64'h8000_0000_0000_0000, 64'h1,
            64'h8000_0000_0000_0001, 64'h0,
            64'h8000_0000_0000_0000);

    // abort together with start in IDLE: nothing starts.
    abort = 1'b1; start = 1'b1;
    tick();
    chk1("abort_start_idle", busy, 1'b0);
    abort = 1'b0; start = 1'b0;

    // abort in SETTLE_NEG.
    pert_a_in = 64'h10; pert_b_in = 64'h3; metric_in = 64'd9; metric_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(S + 2);                            // E(S+2) -> SETTLE_NEG
    tick();
    chk1 ("abort_pre_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1 ("abort_busy", busy, 1'b0);
    chk1 ("abort_done", done, 1'b0);
    chk64("abort_dac_a", dac_a, '0);
    chk64("abort_dac_b", dac_b, '0);
    chk1 ("abort_dv", dac_valid, 1'b1);
    chk64("abort_delta", delta, 64'h8000_0000_0000_0000);
    tick_n(S + 2);
    chk1 ("abort_no_done", done, 1'b0);
    chk1 ("abort_idle", busy, 1'b0);

    do_iter("post_abort", 64'h99, 64'h10, 64'hFFFF_FFFF_FFFF_FFFB,
            64'd100, 64'd40,
            64'hFFFF_FFFF_FFFF_FFF0, 64'h5, 64'd60);

    // rst in MEAS_POS with start high.
    pert_a_in = 64'h21; pert_b_in = 64'h22; sigma_in = 64'h33; metric_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(S + 1);                            // E(S+1) -> MEAS_POS
    tick_n(2);
    chk1 ("meas_wait_busy", busy, 1'b1);
    chk64("meas_wait_dac", dac_a, 64'h21);
    start = 1'b1; rst = 1'b1;
    tick();
    chk1 ("mrst_busy", busy, 1'b0);
    chk64("mrst_dac_a", dac_a, '0);
    chk64("mrst_dac_b", dac_b, '0);
    chk64("mrst_pert_a", pert_a, '0);
    chk64("mrst_pert_b", pert_b, '0);
    chk64("mrst_sigma", prng_sigma, '0);
    chk64("mrst_delta", delta, '0);
    chk1 ("mrst_dv", dac_valid, 1'b0);
    tick();
    chk1 ("mrst_hold", busy, 1'b0);
    rst = 1'b0;
    tick();
    chk1 ("mrst_restart", busy, 1'b1);
    chk64("mrst_resigma", prng_sigma, 64'h33);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1 ("mrst_abort", busy, 1'b0);

`ifdef SPGD_PERT_TIMEOUT_EN
    // Metric never arrives: err after 16 cycles in MEAS_POS.
    metric_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick_n(S + 1);                            // E(S+1) -> MEAS_POS
    tick_n(15);
    chk1("to_err_early", err, 1'b0);
    chk1("to_busy_early", busy, 1'b1);
    tick();
    chk1 ("to_err", err, 1'b1);
    chk1 ("to_busy", busy, 1'b0);
    chk1 ("to_dv", dac_valid, 1'b1);
    chk64("to_dac_a", dac_a, '0);
    tick_n(3);
    chk1("to_err_sticky", err, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("to_err_cleared", err, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    chk1("err_tied", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spgd_pert_seq.md
SPGD_PERT_SEQ -- requirements
Module: spgd_pert_seq

Interface
REQ-001 SHALL have parameter FP_WIDTH, default 64, the two's-complement data width of all perturbation, sigma and metric words.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, the number of settle cycles after each DAC update (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the metric-wait limit (used only with the Configuration macro defined).
REQ-004 SHALL have ports (one per line):
  clk  in  1  sole clock, all flops on rising edge
  rst  in  1  synchronous, active-high reset
  start  in  1  request one SPGD iteration; sampled only in IDLE
  abort  in  1  return to IDLE at next edge from any non-IDLE state
  sigma_in  in  FP_WIDTH  sigma for next iteration
  prng_sigma  out  FP_WIDTH  sigma driven to PRNG
  pert_a_in, pert_b_in  in  FP_WIDTH  PRNG outputs (new sample each cycle)
  metric_in  in  FP_WIDTH  measured cost J
  metric_valid  in  1  metric_in valid this cycle
  dac_a, dac_b  out  FP_WIDTH  applied perturbation, signed
  dac_valid  out  1  one-cycle pulse on each dac_a/dac_b update
  pert_a, pert_b  out  FP_WIDTH  perturbations latched for current iteration
  delta  out  FP_WIDTH  J(+) minus J(-), saturating
  done  out  1  one-cycle pulse; delta, pert_a, pert_b valid
  busy  out  1  high in every state except IDLE
  err  out  1  sticky metric timeout flag; cleared on start or rst

Function
REQ-005 SHALL implement FSM states IDLE, LATCH, SETTLE_POS, MEAS_POS, SETTLE_NEG, MEAS_NEG, DONE.
REQ-006 IDLE: start=1 -> LATCH; sigma_in registered to prng_sigma on that edge; err cleared.
REQ-007 LATCH -> SETTLE_POS unconditionally; pert_a_in/pert_b_in captured into pert_a/pert_b; dac_a/dac_b load +pert; dac_valid pulses the cycle after.
REQ-008 SETTLE_x: counter loads SETTLE_CYCLES-1 on entry, decrements; transitions to MEAS_x on the edge where counter is 0 (exactly SETTLE_CYCLES cycles in state).
REQ-009 MEAS_POS: metric_valid=1 -> capture J(+), go SETTLE_NEG; dac_a/dac_b load negated pert; dac_valid pulses.
REQ-010 Negation SHALL be two's complement, except the most-negative value, which maps to the most-positive value.
REQ-011 MEAS_NEG: metric_valid=1 -> capture J(-), go DONE; delta = J(+) - J(-), computed at FP_WIDTH+1 bits, saturated to FP_WIDTH signed.
REQ-012 DONE: done=1 for one cycle, dac_a/dac_b return to 0 with a dac_valid pulse, -> IDLE; start during DONE is ignored.
REQ-013 metric_valid outside MEAS_x SHALL be ignored.
REQ-014 abort SHALL take priority over all transitions, including start; dac outputs go to 0 with dac_valid pulse; delta unchanged; no done.
REQ-015 Latency start-edge to done with metric_valid held high SHALL be 2*SETTLE_CYCLES+3 cycles.

Reset
REQ-016 rst SHALL force state IDLE; all outputs, including prng_sigma, pert_a, pert_b, delta and err, to 0; counters to 0; rst overrides abort and start, including mid-iteration.

Configuration
REQ-017 Macro SPGD_PERT_TIMEOUT_EN defined: in MEAS_x, TIMEOUT_CYCLES cycles without metric_valid -> err=1 and abort behaviour (REQ-014). Undefined: MEAS_x waits indefinitely; err is tied to 0; no timeout counter is built.

Structure
REQ-018 FSM state enum, saturating-negate and saturating-subtract helper functions SHALL live in shared package spgd_pkg.
REQ-019 The settle/timeout counter SHALL be one sub-module spgd_cycle_timer (load, decrement, zero flag); the PRNG is instantiated outside this block.

Verification
REQ-020 SETTLE_CYCLES=4, pert_a_in=0x10, pert_b_in=-0x5, J(+)=100, J(-)=40, metric_valid high -> dac_a=+0x10 then -0x10, dac_b=-0x5 then +0x5, delta=60, done 11 cycles after start edge.
REQ-021 pert_a_in=0x8000_0000_0000_0000 -> negative phase dac_a=0x7FFF_FFFF_FFFF_FFFF; J(+)=max positive, J(-)=-1 -> delta saturates to 0x7FFF_FFFF_FFFF_FFFF.
REQ-022 abort asserted in SETTLE_NEG -> IDLE next edge, dac_a=dac_b=0, no done, busy=0; new start then completes normally.
REQ-023 Macro defined, TIMEOUT_CYCLES=16, metric_valid never asserted -> err=1 after 16 cycles in MEAS_POS, IDLE, stays set until next start.
REQ-024 rst pulsed in MEAS_POS while start high -> all outputs 0, IDLE; start sampled only after rst deasserts.
